// File: rtl/lfsr_deserializer_if.sv
// lfsr_deserializer_if
//   Bundles the serial input, the parallel output handshake and the status
//   flags of lfsr_deserializer.
//   serial_in    : serial bit from the LFSR OUT pin
//   serial_valid : qualifies serial_in (LFSR valid)
//   data_out     : FIFO head word, first-received bit in the MSB
//   data_valid   : FIFO non-empty
//   data_ready   : consumer accepts data_out on an edge where data_valid=1
//   overflow     : sticky, a completed word was dropped on a full FIFO
//   short_frame  : one-cycle pulse when a partial word is discarded
//   word_count   : total words pushed into the FIFO, wraps at 16 bits
// Modports:
//   master : the deserializer (consumes serial, produces words and flags)
//   slave  : the environment (drives serial and ready, observes the rest)
interface lfsr_deserializer_if #(
  parameter int WIDTH = 4
);
  logic             serial_in;
  logic             serial_valid;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             overflow;
  logic             short_frame;
  logic [15:0]      word_count;

  modport master (
    input  serial_in,
    input  serial_valid,
    input  data_ready,
    output data_out,
    output data_valid,
    output overflow,
    output short_frame,
    output word_count
  );

  modport slave (
    output serial_in,
    output serial_valid,
    output data_ready,
    input  data_out,
    input  data_valid,
    input  overflow,
    input  short_frame,
    input  word_count
  );
endinterface

// File: rtl/lfsr_deserializer.sv
// lfsr_deserializer
//   Packs WIDTH consecutive valid serial bits into a parallel word
//   (first-received bit is the MSB) and queues completed words in a
//   2-entry FIFO drained through a valid/ready handshake.
// Ports:
//   clock : rising-edge clock shared with the LFSR
//   reset : synchronous, active-high; clears all state on the next edge
//   bus   : lfsr_deserializer_if master modport (serial in, word out, flags)
// Parameters:
//   WIDTH : bits per word, legal range 2..16
module lfsr_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  lfsr_deserializer_if.master  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  // Only the low WIDTH-1 bits are ever needed: the final bit of a word
  // arrives on serial_in on the completing edge and is concatenated directly.
  logic [WIDTH-2:0] shreg;

  // Two-entry FIFO kept as head/tail registers so data_out is a flop.
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       fifo_cnt;

  logic             overflow_q;
  logic             short_q;
  logic [15:0]      word_cnt_q;

  logic [WIDTH-1:0] new_word;
  logic             word_done;
  logic             do_pop;
  logic             fifo_full;
  logic             push_ok;

  // Word completion and FIFO push/pop decisions for the coming edge.
  // A pop on the same edge frees a slot, so a full FIFO still accepts.
  always_comb begin
    new_word  = {shreg, bus.serial_in};
    word_done = (state == COLLECT) && bus.serial_valid &&
                (bit_cnt == CNT_W'(WIDTH - 1));
    do_pop    = (fifo_cnt != 2'd0) && bus.data_ready;
    fifo_full = (fifo_cnt == 2'd2);
    push_ok   = word_done && (!fifo_full || do_pop);
  end

  // Collection FSM, FIFO storage and status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fifo_cnt   <= 2'd0;
      overflow_q <= 1'b0;
      short_q    <= 1'b0;
      word_cnt_q <= 16'd0;
    end else begin
      short_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.serial_valid) begin
            shreg   <= new_word[WIDTH-2:0];
            bit_cnt <= CNT_W'(1);
            state   <= COLLECT;
          end
        end
        COLLECT: begin
          if (bus.serial_valid) begin
            shreg <= new_word[WIDTH-2:0];
            if (bit_cnt == CNT_W'(WIDTH - 1)) begin
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else begin
            // valid dropped mid-word: abandon the partial word
            bit_cnt <= '0;
            short_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          bit_cnt <= '0;
          state   <= IDLE;
        end
      endcase

      if (word_done && !push_ok) begin
        overflow_q <= 1'b1;
      end

      if (push_ok) begin
        word_cnt_q <= word_cnt_q + 16'd1;
      end

      // Head always holds the oldest word; on a pop the tail moves up.
      // When the FIFO empties, head keeps its stale value.
      case ({push_ok, do_pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) begin
            head_q <= new_word;
          end else begin
            tail_q <= new_word;
          end
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          if (fifo_cnt == 2'd2) begin
            head_q <= tail_q;
          end
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            head_q <= new_word;
          end else begin
            head_q <= tail_q;
            tail_q <= new_word;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.data_out    = head_q;
  assign bus.data_valid  = (fifo_cnt != 2'd0);
  assign bus.overflow    = overflow_q;
  assign bus.short_frame = short_q;
  assign bus.word_count  = word_cnt_q;

endmodule

// File: tb/tb_lfsr_deserializer.sv
// tb_lfsr_deserializer
//   Self-checking bench for lfsr_deserializer (WIDTH=4). A queue-based
//   reference model tracks collected bits and FIFO contents; a compare
//   process checks every output on every falling edge, and directed
//   frames are also checked against hand-computed literal words.
module tb_lfsr_deserializer;

  localparam int WIDTH = 4;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  lfsr_deserializer_if #(.WIDTH(WIDTH)) bus ();

  lfsr_deserializer #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int assert_count = 0;
  int fail_count   = 0;

  // Reference model state
  logic             bit_q[$];
  logic [WIDTH-1:0] fifo_q[$];
  logic             exp_ovf;
  logic             exp_short;
  logic [15:0]      exp_wc;
  logic             m_pop;
  int               m_occ;
  logic             m_has_word;
  logic [WIDTH-1:0] m_word;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, return at the following falling edge
  // so outputs reflect the edge that sampled these inputs.
  task automatic applyStimulus(input logic rst, input logic valid,
                               input logic bit_in, input logic ready);
    reset            = rst;
    bus.serial_valid = valid;
    bus.serial_in    = bit_in;
    bus.data_ready   = ready;
    @(negedge clock);
  endtask

  task automatic sendWord(input logic [WIDTH-1:0] w, input logic ready);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b1, w[i], ready);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Behavioural model: a word is the last WIDTH valid bits packed MSB
  // first; the FIFO is a queue of at most two words.
  always @(posedge clock) begin
    if (reset) begin
      bit_q.delete();
      fifo_q.delete();
      exp_ovf   = 1'b0;
      exp_short = 1'b0;
      exp_wc    = 16'd0;
    end else begin
      m_occ      = fifo_q.size();
      m_pop      = (m_occ > 0) && bus.data_ready;
      m_has_word = 1'b0;
      m_word     = '0;
      exp_short  = 1'b0;
      if (bus.serial_valid) begin
        bit_q.push_back(bus.serial_in);
        if (bit_q.size() == WIDTH) begin
          for (int i = 0; i < WIDTH; i++) begin
            m_word = (m_word << 1) | WIDTH'(bit_q[i]);
          end
          m_has_word = 1'b1;
          bit_q.delete();
        end
      end else if (bit_q.size() > 0) begin
        exp_short = 1'b1;
        bit_q.delete();
      end
      if (m_pop) begin
        void'(fifo_q.pop_front());
      end
      if (m_has_word) begin
        if (m_occ < 2 || m_pop) begin
          fifo_q.push_back(m_word);
          exp_wc = exp_wc + 16'd1;
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
  end

  // Compare process: every falling edge after the first rising edge.
  initial begin
    @(posedge clock);
    forever begin
      @(negedge clock);
      checkOutput("model_data_valid", 32'(bus.data_valid), 32'(fifo_q.size() != 0));
      if (fifo_q.size() != 0) begin
        checkOutput("model_data_out", 32'(bus.data_out), 32'(fifo_q[0]));
      end
      checkOutput("model_overflow", 32'(bus.overflow), 32'(exp_ovf));
      checkOutput("model_short_frame", 32'(bus.short_frame), 32'(exp_short));
      checkOutput("model_word_count", 32'(bus.word_count), 32'(exp_wc));
    end
  end

  initial begin
    reset            = 1'b1;
    bus.serial_valid = 1'b0;
    bus.serial_in    = 1'b0;
    bus.data_ready   = 1'b0;
    @(negedge clock);
    doReset();

    $display("[TB] reset state");
    checkOutput("rst_data_out", 32'(bus.data_out), 32'h0);
    checkOutput("rst_data_valid", 32'(bus.data_valid), 32'h0);
    checkOutput("rst_overflow", 32'(bus.overflow), 32'h0);
    checkOutput("rst_short_frame", 32'(bus.short_frame), 32'h0);
    checkOutput("rst_word_count", 32'(bus.word_count), 32'h0);

    $display("[TB] single word 1001");
    sendWord(4'b1001, 1'b1);
    checkOutput("t1_data_out", 32'(bus.data_out), 32'h9);
    checkOutput("t1_data_valid", 32'(bus.data_valid), 32'h1);
    checkOutput("t1_word_count", 32'(bus.word_count), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t1_drained", 32'(bus.data_valid), 32'h0);

    $display("[TB] continuous stream");
    doReset();
    sendWord(4'hD, 1'b1);
    checkOutput("t2_word_d", 32'(bus.data_out), 32'hD);
    sendWord(4'h2, 1'b1);
    checkOutput("t2_word_2", 32'(bus.data_out), 32'h2);
    sendWord(4'hF, 1'b1);
    checkOutput("t2_word_f", 32'(bus.data_out), 32'hF);
    checkOutput("t2_word_count", 32'(bus.word_count), 32'h3);
    checkOutput("t2_overflow", 32'(bus.overflow), 32'h0);

    $display("[TB] backpressure with overflow");
    doReset();
    sendWord(4'hA, 1'b0);
    sendWord(4'h5, 1'b0);
    sendWord(4'h3, 1'b0);
    checkOutput("t3_head", 32'(bus.data_out), 32'hA);
    checkOutput("t3_overflow", 32'(bus.overflow), 32'h1);
    checkOutput("t3_word_count", 32'(bus.word_count), 32'h2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t3_second", 32'(bus.data_out), 32'h5);
    checkOutput("t3_second_valid", 32'(bus.data_valid), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t3_empty", 32'(bus.data_valid), 32'h0);
    checkOutput("t3_overflow_sticky", 32'(bus.overflow), 32'h1);

    $display("[TB] push and pop on a full FIFO");
    doReset();
    sendWord(4'hA, 1'b0);
    sendWord(4'h5, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("t4_head", 32'(bus.data_out), 32'h5);
    checkOutput("t4_word_count", 32'(bus.word_count), 32'h3);
    checkOutput("t4_overflow", 32'(bus.overflow), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_third", 32'(bus.data_out), 32'h3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_empty", 32'(bus.data_valid), 32'h0);

    $display("[TB] truncated frame");
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t5_short_pulse", 32'(bus.short_frame), 32'h1);
    checkOutput("t5_no_push", 32'(bus.word_count), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t5_short_clear", 32'(bus.short_frame), 32'h0);
    sendWord(4'b0110, 1'b1);
    checkOutput("t5_next_word", 32'(bus.data_out), 32'h6);
    checkOutput("t5_word_count", 32'(bus.word_count), 32'h1);

    $display("[TB] reset mid-word with overflow set");
    doReset();
    sendWord(4'hC, 1'b0);
    sendWord(4'hC, 1'b0);
    sendWord(4'hC, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("t6_data_valid", 32'(bus.data_valid), 32'h0);
    checkOutput("t6_word_count", 32'(bus.word_count), 32'h0);
    checkOutput("t6_overflow", 32'(bus.overflow), 32'h0);
    checkOutput("t6_short_frame", 32'(bus.short_frame), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t6_no_short_after", 32'(bus.short_frame), 32'h0);
    sendWord(4'b1001, 1'b1);
    checkOutput("t6_next_word", 32'(bus.data_out), 32'h9);
    checkOutput("t6_next_count", 32'(bus.word_count), 32'h1);

    $display("[TB] mixed valid/ready pattern");
    doReset();
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'b0, (i % 7) != 6, ((i * 3) % 5) >= 2, (i % 5) < 2);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("t7_drained", 32'(bus.data_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
